pc_sequencer: RTL and testbench

Program-counter register and next-PC sequencer that sits directly downstream of the jump/branch control unit. It consumes the unit's 2-bit PC-select code (00 sequential, 01 PC-relative, 10 memory-addressed, 11 register-target) and computes the next fetch address. For memory-addressed jumps (`jrs`, `jmsub`), it performs a data-memory read handshake to fetch the target. It also issues link-register writes for `jmsub` and `balrn`.

---
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: sequential, PC-relative, register and
// memory-indirect jumps, with link-register strobes and a bounded memory wait.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] imm,
  input  logic [31:0] rs_val,
  input  logic        jmsub,
  input  logic        stall,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] pc,
  output logic        busy,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        err
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pc_plus4;
  logic [31:0]   rel_off;

  assign pc_plus4 = pc + 32'd4;
  assign rel_off  = imm << 2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      pc        <= RESET_PC;
      dmem_req  <= 1'b0;
      dmem_addr <= '0;
      busy      <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
      err       <= 1'b0;
    end else begin
      link_we <= 1'b0;
      case (state)
        RUN: begin
          if (!stall) begin
            case (pc_sel)
              2'b00: pc <= pc_plus4;
              2'b01: pc <= pc_plus4 + rel_off;
              2'b11: begin
                pc        <= rs_val & WORD_MASK;
                link_we   <= 1'b1;
                link_data <= pc_plus4;
              end
              2'b10: begin
                dmem_addr <= rs_val;
                dmem_req  <= 1'b1;
                busy      <= 1'b1;
                cnt       <= '0;
                state     <= MEM_WAIT;
                if (jmsub) begin
                  link_we   <= 1'b1;
                  link_data <= pc_plus4;
                end
              end
            endcase
          end
        end
        MEM_WAIT: begin
          cnt <= cnt + CW'(1);
          // An ack on the final wait cycle takes priority over the timeout
          if (dmem_ack) begin
            pc       <= dmem_rdata & WORD_MASK;
            dmem_req <= 1'b0;
            busy     <= 1'b0;
            state    <= RUN;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            pc       <= RESET_PC;
            dmem_req <= 1'b0;
            busy     <= 1'b0;
            state    <= RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// stimulus, all compared against a transaction-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_sel;
  logic [31:0] imm, rs_val, dmem_rdata;
  logic        jmsub, stall, dmem_ack;
  logic        dmem_req, busy, link_we, err;
  logic [31:0] dmem_addr, pc, link_data;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_addr, m_link_data;
  logic        m_req, m_link_we, m_err, m_waiting;
  int          m_elapsed;

  pc_sequencer #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pc_sel(pc_sel), .imm(imm), .rs_val(rs_val),
    .jmsub(jmsub), .stall(stall), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .pc(pc), .busy(busy),
    .link_we(link_we), .link_data(link_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the currently applied inputs
  task automatic model_step();
    if (reset) begin
      m_pc = RPC; m_addr = 0; m_link_data = 0; m_req = 0;
      m_link_we = 0; m_err = 0; m_waiting = 0; m_elapsed = 0;
    end else if (!m_waiting) begin
      m_link_we = 0;
      if (!stall) begin
        case (pc_sel)
          2'd0: m_pc = m_pc + 4;
          2'd1: m_pc = m_pc + 4 + imm * 4;
          2'd3: begin
            m_link_we = 1; m_link_data = m_pc + 4;
            m_pc = {rs_val[31:2], 2'b00};
          end
          default: begin
            m_addr = rs_val; m_req = 1; m_waiting = 1; m_elapsed = 0;
            if (jmsub) begin m_link_we = 1; m_link_data = m_pc + 4; end
          end
        endcase
      end
    end else begin
      m_link_we = 0;
      m_elapsed++;
      if (dmem_ack) begin
        m_pc = {dmem_rdata[31:2], 2'b00}; m_req = 0; m_waiting = 0;
      end else if (m_elapsed == TMO) begin
        m_err = 1; m_pc = RPC; m_req = 0; m_waiting = 0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("dmem_req", 32'(dmem_req), 32'(m_req));
    chk("dmem_addr", dmem_addr, m_addr);
    chk("busy", 32'(busy), 32'(m_waiting));
    chk("link_we", 32'(link_we), 32'(m_link_we));
    chk("link_data", link_data, m_link_data);
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic jump_to(input logic [31:0] target);
    pc_sel = 2'b11; rs_val = target; step();
  endtask

  initial begin
    reset = 1; pc_sel = 0; imm = 0; rs_val = 0; jmsub = 0; stall = 0;
    dmem_ack = 0; dmem_rdata = 0;
    m_pc = 0; m_addr = 0; m_link_data = 0; m_req = 0; m_link_we = 0;
    m_err = 0; m_waiting = 0; m_elapsed = 0;
    #2;
    step();
    chk("reset_pc", pc, 32'h100);

    // Sequential run
    reset = 0; pc_sel = 2'b00;
    step(); chk("seq1", pc, 32'h104);
    step(); chk("seq2", pc, 32'h108);
    step(); chk("seq3", pc, 32'h10C);
    chk("seq_link_we", 32'(link_we), 32'd0);

    // PC-relative branches
    jump_to(32'h200);
    pc_sel = 2'b01; imm = 32'hFFFF_FFFE; step(); chk("rel_neg", pc, 32'h1FC);
    jump_to(32'h200);
    pc_sel = 2'b01; imm = 32'd3; step(); chk("rel_pos", pc, 32'h210);

    // Register target with link
    jump_to(32'h300);
    jump_to(32'h1237);
    chk("reg_pc", pc, 32'h1234);
    chk("reg_link_we", 32'(link_we), 32'd1);
    chk("reg_link_data", link_data, 32'h304);

    // Wrap-around of pc+4
    jump_to(32'hFFFF_FFFC);
    pc_sel = 2'b00; step(); chk("wrap", pc, 32'h0);

    // Memory jump with link; ack arrives on the last allowed wait cycle
    jump_to(32'h400);
    pc_sel = 2'b10; jmsub = 1; rs_val = 32'h80; step();
    chk("mj_req", 32'(dmem_req), 32'd1);
    chk("mj_addr", dmem_addr, 32'h80);
    chk("mj_busy", 32'(busy), 32'd1);
    chk("mj_link_we", 32'(link_we), 32'd1);
    chk("mj_link_data", link_data, 32'h404);
    jmsub = 0;
    for (int i = 0; i < 3; i++) begin
      pc_sel = 2'(i); rs_val = 32'hDEAD_0000 + 32'(i); step();
      chk("mj_wait_pc", pc, 32'h400);
    end
    dmem_ack = 1; dmem_rdata = 32'h5000; step(); dmem_ack = 0;
    chk("mj_pc", pc, 32'h5000);
    chk("mj_req_done", 32'(dmem_req), 32'd0);
    chk("mj_no_err", 32'(err), 32'd0);

    // Timeout, then a stray ack in RUN
    pc_sel = 2'b10; rs_val = 32'h84; step();
    pc_sel = 2'b00;
    for (int i = 0; i < TMO; i++) step();
    chk("to_err", 32'(err), 32'd1);
    chk("to_pc", pc, RPC);
    dmem_ack = 1; dmem_rdata = 32'h9000; step(); dmem_ack = 0;
    chk("to_stray_ack", pc, RPC + 32'd4);

    // Reset mid-wait together with an ack
    jump_to(32'h600);
    pc_sel = 2'b10; rs_val = 32'h90; step();
    pc_sel = 2'b00; step();
    reset = 1; dmem_ack = 1; dmem_rdata = 32'h7000; step();
    reset = 0; dmem_ack = 0;
    chk("rst_pc", pc, RPC);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Stall blocks a register jump
    stall = 1; pc_sel = 2'b11; rs_val = 32'h999; step();
    chk("stall_pc", pc, RPC);
    chk("stall_link_we", 32'(link_we), 32'd0);
    stall = 0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 79) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      pc_sel     = 2'($urandom_range(0, 3));
      imm        = $urandom;
      rs_val     = $urandom;
      jmsub      = 1'($urandom_range(0, 1));
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
